serial_subtractor: RTL and testbench

//   Bit-serial subtractor: the inverse-direction counterpart of the combinational full adder.

---
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = ip1 - ip2 - b_in, one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flop.
//
// state | meaning
// IDLE  | waiting for start; diff/b_out hold the last result
// SHIFT | one result bit per cycle, WIDTH cycles total
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_bits_left;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_b_out;

    logic             w_d;
    logic             w_bn;

    assign w_d  = r_a[0] ^ r_b[0] ^ r_br;
    assign w_bn = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    // Bit counter runs down from WIDTH-1; the terminal edge is when it reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_br        <= 1'b0;
            r_bits_left <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_diff      <= '0;
            r_b_out     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a         <= ip1;
                        r_b         <= ip2;
                        r_br        <= b_in;
                        r_bits_left <= CW'(WIDTH - 1);
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_res       <= {w_d, r_res[WIDTH-1:1]};
                    r_a         <= r_a >> 1;
                    r_b         <= r_b >> 1;
                    r_br        <= w_bn;
                    r_bits_left <= r_bits_left - CW'(1);
                    if (r_bits_left == '0) begin
                        r_diff  <= {w_d, r_res[WIDTH-1:1]};
                        r_b_out <= w_bn;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_b_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=8 and WIDTH=2),
// checked against a plain-arithmetic subtraction model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] ip1;
    logic [7:0] ip2;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       b_out;

    logic       start2;
    logic [1:0] ip1_2;
    logic [1:0] ip2_2;
    logic       b_in2;
    logic       busy2;
    logic       done2;
    logic [1:0] diff2;
    logic       b_out2;

    int n_checks;
    int n_pass;

    int exp_diff_q;
    int exp_bout_q;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ip1   (ip1),
        .ip2   (ip2),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .ip1   (ip1_2),
        .ip2   (ip2_2),
        .b_in  (b_in2),
        .busy  (busy2),
        .done  (done2),
        .diff  (diff2),
        .b_out (b_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: unsigned subtraction modulo 2^w; borrow bit placed above the difference.
    function automatic int ref_sub(input int a, input int b, input int bin, input int w);
        int d;
        int borrow;
        d      = (a - b - bin) & ((1 << w) - 1);
        borrow = (a < b + bin) ? 1 : 0;
        return (borrow << w) | d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
        ip1   = a;
        ip2   = b;
        b_in  = bin;
        start = 1'b1;
    endtask

    // Runs from the accepting edge to the done cycle; returns with done expected high.
    task automatic finish_op(input logic interfere);
        int r;
        int ed;
        int eb;
        r  = ref_sub(int'(ip1), int'(ip2), int'(b_in), 8);
        ed = r & 8'hFF;
        eb = (r >> 8) & 1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                check("busy_during_op", 32'(busy), 32'd1);
                check("no_early_done", 32'(done), 32'd0);
                check("diff_held", 32'(diff), 32'(exp_diff_q));
                if (interfere && k == 3) begin
                    start = 1'b1;
                    ip1   = 8'($urandom);
                    ip2   = 8'($urandom);
                    b_in  = 1'($urandom);
                end
                if (interfere && k == 4)
                    start = 1'b0;
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_clear", 32'(busy), 32'd0);
                check("diff", 32'(diff), 32'(ed));
                check("b_out", 32'(b_out), 32'(eb));
            end
        end
        exp_diff_q = ed;
        exp_bout_q = eb;
    endtask

    task automatic idle_after_done();
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("diff_hold_idle", 32'(diff), 32'(exp_diff_q));
        check("bout_hold_idle", 32'(b_out), 32'(exp_bout_q));
    endtask

    initial begin
        int r;
        n_checks   = 0;
        n_pass     = 0;
        exp_diff_q = 0;
        exp_bout_q = 0;
        start  = 1'b1;
        ip1    = 8'h77;
        ip2    = 8'h11;
        b_in   = 1'b1;
        start2 = 1'b0;
        ip1_2  = '0;
        ip2_2  = '0;
        b_in2  = 1'b0;
        rst_n  = 1'b0;

        // Reset with start asserted
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(b_out), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Directed operations
        launch(8'h5A, 8'h23, 1'b0);
        finish_op(1'b0);
        check("dir_5A_23", 32'(diff), 32'h37);
        idle_after_done();

        launch(8'h10, 8'h20, 1'b1);
        finish_op(1'b0);
        check("dir_10_20_b", 32'(diff), 32'hEF);
        check("dir_10_20_bo", 32'(b_out), 32'd1);
        idle_after_done();

        launch(8'h00, 8'h00, 1'b1);
        finish_op(1'b0);
        check("dir_wrap", 32'(diff), 32'hFF);
        check("dir_wrap_bo", 32'(b_out), 32'd1);
        idle_after_done();

        launch(8'hA5, 8'hA5, 1'b0);
        finish_op(1'b0);
        check("dir_equal", 32'(diff), 32'h00);
        check("dir_equal_bo", 32'(b_out), 32'd0);
        idle_after_done();

        // Interference while busy, then back-to-back start in the done cycle
        launch(8'hC3, 8'h4E, 1'b1);
        finish_op(1'b1);
        check("interf_diff", 32'(diff), 32'h74);
        launch(8'h31, 8'h9C, 1'b0);
        finish_op(1'b0);
        idle_after_done();

        // Reset mid-operation
        launch(8'h99, 8'h12, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(b_out), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        exp_diff_q = 0;
        exp_bout_q = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        launch(8'hFF, 8'h01, 1'b0);
        finish_op(1'b0);
        check("post_abort", 32'(diff), 32'hFE);
        idle_after_done();

        // Randomized ops, some with interference, some chained
        for (int n = 0; n < 30; n++) begin
            launch(8'($urandom), 8'($urandom), 1'($urandom));
            finish_op(1'($urandom));
            if ($urandom_range(0, 1) == 0)
                idle_after_done();
        end
        idle_after_done();

        // WIDTH=2 exhaustive sweep, back-to-back
        for (int i = 0; i < 32; i++) begin
            ip1_2  = 2'(i >> 3);
            ip2_2  = 2'(i >> 1);
            b_in2  = 1'(i);
            start2 = 1'b1;
            r = ref_sub(i >> 3, (i >> 1) & 3, i & 1, 2);
            tick();
            start2 = 1'b0;
            tick();
            check("w2_busy", 32'(busy2), 32'd1);
            check("w2_nodone", 32'(done2), 32'd0);
            tick();
            check("w2_done", 32'(done2), 32'd1);
            check("w2_diff", 32'(diff2), 32'(r & 3));
            check("w2_bout", 32'(b_out2), 32'((r >> 2) & 1));
        end
        tick();
        check("w2_done_clear", 32'(done2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
